// File: rtl/muldiv_pkg.sv
// Shared definitions for the EXE-stage HI/LO arithmetic unit:
// op encodings, FSM states and the divide iteration count.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    // W quotient-bit iterations plus one sign-fixup cycle.
    function automatic int div_cycles(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle,
// W iterations after load, last_o high once the result is stable.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o,
    output logic         last_o
);

    localparam int CW = $clog2(div_cycles(W));

    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;
    logic          ge;

    // A zero divisor always "fits", giving an all-ones quotient and |a| as remainder.
    always_comb begin
        rem_sh = {rem_q, quot_q[W-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        ge     = ~diff[W];
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dvsr_d = divisor_i;
            cnt_d  = '0;
        end else if (cnt_q != CW'(W)) begin
            rem_d  = ge ? diff[W-1:0] : rem_sh[W-1:0];
            quot_d = {quot_q[W-2:0], ge};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= CW'(W);
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CW'(W));

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage HI/LO unit: pipelined multiply, iterative divide, MTHI/MTLO,
// with cancel for pipeline flushes. Owns the architectural HI/LO registers.
module exe_muldiv
    import muldiv_pkg::*;
#(
    parameter int W          = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    state_e                state_q, state_d;
    logic [W-1:0]          hi_q, hi_d, lo_q, lo_d;
    logic                  done_q, done_d, dbz_q, dbz_d;
    logic [MUL_STAGES-1:0] mul_vld_q, mul_vld_d;
    logic [2*W-1:0]        mul_a_q, mul_b_q, mul_prod;
    logic                  div_qneg_q, div_rneg_q, div_bz_q;
    logic                  accept, is_mul, is_div, is_signed;
    logic [W-1:0]          a_mag, b_mag, div_quot, div_rem;
    logic                  div_last;

    always_comb begin
        accept    = start & ~cancel & (state_q == S_IDLE);
        is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        is_div    = (op == OP_DIV)  || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = (is_signed && a[W-1]) ? -a : a;
        b_mag     = (is_signed && b[W-1]) ? -b : b;
        mul_prod  = mul_a_q * mul_b_q;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        mul_vld_d = mul_vld_q << 1;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d      = S_MUL;
                        mul_vld_d[0] = 1'b1;
                    end else if (is_div) begin
                        state_d = S_DIV;
                    end else if (op == OP_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_d   = S_IDLE;
                    mul_vld_d = '0;
                end else if (mul_vld_q[MUL_STAGES-1]) begin
                    state_d      = S_IDLE;
                    {hi_d, lo_d} = mul_prod;
                    done_d       = 1'b1;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (div_last) begin
                    state_d = S_IDLE;
                    lo_d    = div_qneg_q ? -div_quot : div_quot;
                    hi_d    = div_rneg_q ? -div_rem : div_rem;
                    done_d  = 1'b1;
                    dbz_d   = div_bz_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            mul_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            mul_vld_q <= mul_vld_d;
        end
    end

    // NOTE: operand/sign registers are only read while their op is in flight,
    // so they carry no reset; the control path above is what reset must clear.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mul_a_q <= is_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
            mul_b_q <= is_signed ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        end
        if (accept && is_div) begin
            div_qneg_q <= is_signed & (a[W-1] ^ b[W-1]);
            div_rneg_q <= is_signed & a[W-1];
            div_bz_q   <= (b == '0);
        end
    end

    muldiv_div_core #(.W(W)) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept & is_div),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quot_o     (div_quot),
        .rem_o      (div_rem),
        .last_o     (div_last)
    );

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv; three instances share stimulus so multiply
// latency can be compared across MUL_STAGES = 1, 2 and 4.
module tb_exe_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         busy1, done1, dbz1, busy2, done2, dbz2, busy4, done4, dbz4;
    logic [W-1:0] hi1, lo1, hi2, lo2, hi4, lo4;

    int checks = 0;
    int errors = 0;
    int cyc;
    int done_seen;

    always #5 clk = ~clk;

    exe_muldiv #(.W(W), .MUL_STAGES(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy1), .done(done1), .dbz(dbz1), .hi(hi1), .lo(lo1));
    exe_muldiv #(.W(W), .MUL_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy2), .done(done2), .dbz(dbz2), .hi(hi2), .lo(lo2));
    exe_muldiv #(.W(W), .MUL_STAGES(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy4), .done(done4), .dbz(dbz4), .hi(hi4), .lo(lo4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts busy cycles of the MUL_STAGES=2 instance, bounded at 100.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy2 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_hi", hi2, 0);
        check("rst_lo", lo2, 0);
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_dbz", dbz2, 0);

        // MULT -3 * 5
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_busy_after_e0", busy2, 1);
        wait_idle(cyc);
        check("mult_busy_cycles", cyc, 2);
        check("mult_done", done2, 1);
        check("mult_hi", hi2, 32'hFFFF_FFFF);
        check("mult_lo", lo2, 32'hFFFF_FFF1);
        check("mult_dbz", dbz2, 0);
        tick();
        check("mult_done_pulse", done2, 0);
        tick();
        tick();
        tick();

        // MULTU latency across depths
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("multu_busy1_k%0d", k), busy1, (k <= 1));
            check($sformatf("multu_busy2_k%0d", k), busy2, (k <= 2));
            check($sformatf("multu_busy4_k%0d", k), busy4, (k <= 4));
            check($sformatf("multu_done1_k%0d", k), done1, (k == 2));
            check($sformatf("multu_done2_k%0d", k), done2, (k == 3));
            check($sformatf("multu_done4_k%0d", k), done4, (k == 5));
            tick();
        end
        check("multu_hi1", hi1, 32'hFFFF_FFFE);
        check("multu_lo1", lo1, 32'h0000_0001);
        check("multu_hi2", hi2, 32'hFFFF_FFFE);
        check("multu_lo2", lo2, 32'h0000_0001);
        check("multu_hi4", hi4, 32'hFFFF_FFFE);
        check("multu_lo4", lo4, 32'h0000_0001);

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        check("div_busy_cycles", cyc, 33);
        check("div_done", done2, 1);
        check("div_lo", lo2, 32'hFFFF_FFFD);
        check("div_hi", hi2, 32'hFFFF_FFFF);
        check("div_dbz", dbz2, 0);
        tick();

        // DIV signed overflow
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("divovf_done", done2, 1);
        check("divovf_lo", lo2, 32'h8000_0000);
        check("divovf_hi", hi2, 32'h0000_0000);
        tick();

        // DIVU by zero
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_idle(cyc);
        check("dbz_done", done2, 1);
        check("dbz_flag2", dbz2, 1);
        check("dbz_flag1", dbz1, 1);
        check("dbz_flag4", dbz4, 1);
        check("dbz_lo", lo2, 32'hFFFF_FFFF);
        check("dbz_hi", hi2, 32'h0000_0064);
        tick();
        check("dbz_pulse", dbz2, 0);
        check("dbz_done_pulse", done2, 0);

        // DIV cancelled mid-flight, with start held (ignored) while busy
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hDEAD_BEEF;
        repeat (8) tick();
        check("held_start_busy", busy2, 1);
        check("held_start_hi", hi2, 32'h0000_0064);
        start  = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", busy2, 0);
        check("cancel_done", done2, 0);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done2) done_seen++;
        end
        check("cancel_no_done", done_seen, 0);
        check("cancel_hi", hi2, 32'h0000_0064);
        check("cancel_lo", lo2, 32'hFFFF_FFFF);

        // cancel on the commit edge beats the commit
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (32) tick();
        check("cedge_busy_before", busy2, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cedge_busy", busy2, 0);
        check("cedge_done", done2, 0);
        check("cedge_hi", hi2, 32'h0000_0064);
        check("cedge_lo", lo2, 32'hFFFF_FFFF);
        done_seen = 0;
        repeat (3) begin
            tick();
            if (done2) done_seen++;
        end
        check("cedge_no_done", done_seen, 0);

        // cancel together with MTHI start
        start  = 1'b1;
        op     = OP_MTHI;
        a      = 32'h1111_1111;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("cstart_done", done2, 0);
        check("cstart_hi", hi2, 32'h0000_0064);

        // MTLO then MTHI back to back
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h1234_5678;
        tick();
        check("mtlo_done", done2, 1);
        check("mtlo_lo", lo2, 32'h1234_5678);
        check("mtlo_busy", busy2, 0);
        op = OP_MTHI;
        a  = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        check("mthi_done", done2, 1);
        check("mthi_hi", hi2, 32'h9ABC_DEF0);
        check("mthi_lo_kept", lo2, 32'h1234_5678);
        tick();
        check("mthi_done_pulse", done2, 0);

        // reset in the middle of a multiply
        issue(OP_MULT, 32'd3, 32'd5);
        check("rstmul_busy", busy2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmul_hi", hi2, 0);
        check("rstmul_lo", lo2, 0);
        check("rstmul_busy0", busy2, 0);
        check("rstmul_done", done2, 0);
        check("rstmul_dbz", dbz2, 0);
        done_seen = 0;
        repeat (6) begin
            tick();
            if (done2) done_seen++;
        end
        check("rstmul_no_done", done_seen, 0);
        check("rstmul_hi_after", hi2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
